// File: rtl/accum_wavefront_sequencer.sv
// rtl/accum_wavefront_sequencer.sv - skewed, lane-masked accumulator strobe sequencer for an N x N MAC array
// Optional feature macro: ACCUM_STALL_CNT_EN (adds stall_cycles_o).
module accum_wavefront_sequencer #(
    parameter int MUL_SIZE  = 32,
    parameter int ACC_DEPTH = 1024,
    parameter int DIM_W     = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic [DIM_W-1:0]             cmd_v_dim_i,
    input  logic [DIM_W-1:0]             cmd_u_dim_i,
    input  logic                         cmd_accumulate_i,
    input  logic                         act_start_i,
    input  logic                         stall_i,
    output logic                         acc_wr_en_o,
    output logic [$clog2(ACC_DEPTH)-1:0] acc_wr_addr_o,
    output logic [MUL_SIZE-1:0]          acc_wr_mask_o,
    output logic                         acc_rd_en_o,
    output logic [$clog2(ACC_DEPTH)-1:0] acc_rd_addr_o,
    output logic                         acc_add_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o
`ifdef ACCUM_STALL_CNT_EN
    ,
    output logic [31:0]                  stall_cycles_o
`endif
);
    localparam int N  = MUL_SIZE;
    localparam int LN = $clog2(MUL_SIZE);
    localparam int AW = $clog2(ACC_DEPTH);
    localparam int KW = DIM_W + LN + 1;

    typedef enum logic [1:0] {IDLE, WAIT_ACT, FILL, WAVE} state_t;

    state_t        r_state, w_state_nxt;
    logic [KW-1:0] r_k, w_k_nxt;
    logic [KW-1:0] r_tile, w_tile_nxt;
    logic [KW-1:0] r_x, r_v;
    logic [AW-1:0] r_base, w_base_nxt;
    logic          r_acc;
    logic [KW-1:0] w_s, w_x;
    logic          w_accept, w_reject, w_done;
    logic          w_add_cond, w_wr_en, w_rd_en;
    logic [N-1:0]  w_mask;
    logic [AW-1:0] w_rd_addr;

    assign w_s = r_v + KW'(N - 1);
    assign w_x = (KW'(cmd_u_dim_i) + KW'(N - 1)) >> LN;

    // Outputs are derived from next-state values so the registered strobes line up with the state they describe.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_tile_nxt  = r_tile;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    w_accept = 1'b1;
                    if (cmd_v_dim_i == '0 || cmd_u_dim_i == '0) begin
                        w_reject = 1'b1;
                    end else begin
                        w_state_nxt = WAIT_ACT;
                        w_tile_nxt  = '0;
                    end
                end
            end
            WAIT_ACT: begin
                if (!stall_i && act_start_i) begin
                    w_state_nxt = FILL;
                    w_k_nxt     = '0;
                end
            end
            FILL: begin
                if (!stall_i) begin
                    if (r_k == KW'(N - 2)) begin
                        w_state_nxt = WAVE;
                        w_k_nxt     = '0;
                    end else begin
                        w_k_nxt = r_k + KW'(1);
                    end
                end
            end
            WAVE: begin
                if (!stall_i) begin
                    if (r_k == w_s - KW'(1)) begin
                        if (r_tile + KW'(1) < r_x) begin
                            w_state_nxt = WAIT_ACT;
                            w_tile_nxt  = r_tile + KW'(1);
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_k_nxt = r_k + KW'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        w_done     = !stall_i && (w_state_nxt == WAVE) && (w_k_nxt == w_s - KW'(1))
                     && (w_tile_nxt + KW'(1) >= r_x);
        w_base_nxt = w_done ? r_base + AW'(w_s) : r_base;
        w_add_cond = (w_tile_nxt != '0) || r_acc;
        w_wr_en    = !stall_i && (w_state_nxt == WAVE);
        // Read leads its write by one cycle; step 0's read lands in the last FILL cycle.
        w_rd_en    = !stall_i && w_add_cond
                     && (((w_state_nxt == FILL) && (w_k_nxt == KW'(N - 2)))
                         || ((w_state_nxt == WAVE) && (w_k_nxt + KW'(1) < w_s)));
        w_rd_addr  = r_base + ((w_state_nxt == WAVE) ? AW'(w_k_nxt + KW'(1)) : '0);

        w_mask = '0;
        for (int j = 0; j < N; j++) begin
            w_mask[j] = (w_k_nxt >= KW'(j)) && (w_k_nxt < KW'(j) + r_v);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= IDLE;
            r_k           <= '0;
            r_tile        <= '0;
            r_x           <= '0;
            r_v           <= '0;
            r_acc         <= 1'b0;
            r_base        <= '0;
            cmd_ready_o   <= 1'b1;
            acc_wr_en_o   <= 1'b0;
            acc_wr_addr_o <= '0;
            acc_wr_mask_o <= '0;
            acc_rd_en_o   <= 1'b0;
            acc_rd_addr_o <= '0;
            acc_add_o     <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_tile  <= w_tile_nxt;
            r_base  <= w_base_nxt;
            if (w_accept) begin
                r_v   <= KW'(cmd_v_dim_i);
                r_x   <= w_x;
                r_acc <= cmd_accumulate_i;
            end
            cmd_ready_o   <= (w_state_nxt == IDLE) && !w_done && !w_reject;
            acc_wr_en_o   <= w_wr_en;
            acc_wr_addr_o <= w_wr_en ? r_base + AW'(w_k_nxt) : '0;
            acc_wr_mask_o <= w_wr_en ? w_mask : '0;
            acc_rd_en_o   <= w_rd_en;
            acc_rd_addr_o <= w_rd_en ? w_rd_addr : '0;
            acc_add_o     <= (w_state_nxt == WAVE) && w_add_cond;
            busy_o        <= (w_state_nxt != IDLE);
            done_o        <= w_done || w_reject;
            err_o         <= w_reject;
        end
    end

`ifdef ACCUM_STALL_CNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cycles_o <= '0;
        end else if (w_accept) begin
            stall_cycles_o <= '0;
        end else if (stall_i && busy_o && (stall_cycles_o != 32'hFFFF_FFFF)) begin
            stall_cycles_o <= stall_cycles_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_accum_wavefront_sequencer.sv
// tb/tb_accum_wavefront_sequencer.sv - directed self-checking bench for accum_wavefront_sequencer (N=4, depth 16)
module tb_accum_wavefront_sequencer;
    localparam int N = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [7:0]  cmd_v_dim_i;
    logic [7:0]  cmd_u_dim_i;
    logic        cmd_accumulate_i;
    logic        act_start_i;
    logic        stall_i;
    logic        acc_wr_en_o;
    logic [3:0]  acc_wr_addr_o;
    logic [3:0]  acc_wr_mask_o;
    logic        acc_rd_en_o;
    logic [3:0]  acc_rd_addr_o;
    logic        acc_add_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
`ifdef ACCUM_STALL_CNT_EN
    logic [31:0] stall_cycles_o;
`endif

    int n_checks;
    int n_fail;

    // Hand-derived lane masks per step for V=3 and V=2.
    logic [3:0] m3 [6] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8};
    logic [3:0] m2 [5] = '{4'h1, 4'h3, 4'h6, 4'hC, 4'h8};

    accum_wavefront_sequencer #(
        .MUL_SIZE (4),
        .ACC_DEPTH(16),
        .DIM_W    (8)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_v_dim_i     (cmd_v_dim_i),
        .cmd_u_dim_i     (cmd_u_dim_i),
        .cmd_accumulate_i(cmd_accumulate_i),
        .act_start_i     (act_start_i),
        .stall_i         (stall_i),
        .acc_wr_en_o     (acc_wr_en_o),
        .acc_wr_addr_o   (acc_wr_addr_o),
        .acc_wr_mask_o   (acc_wr_mask_o),
        .acc_rd_en_o     (acc_rd_en_o),
        .acc_rd_addr_o   (acc_rd_addr_o),
        .acc_add_o       (acc_add_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o)
`ifdef ACCUM_STALL_CNT_EN
        ,
        .stall_cycles_o  (stall_cycles_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input int v, input int u, input bit acc);
        check_eq("ready before accept", 32'(cmd_ready_o), 1);
        cmd_valid_i      = 1'b1;
        cmd_v_dim_i      = 8'(v);
        cmd_u_dim_i      = 8'(u);
        cmd_accumulate_i = acc;
        step();
        cmd_valid_i      = 1'b0;
    endtask

    task automatic act();
        act_start_i = 1'b1;
        step();
        act_start_i = 1'b0;
    endtask

    // Entered in cycle t0+1; returns in the cycle of the tile's final write.
    task automatic check_wave(input string tag, input int base, input int v, input bit add,
                              input bit last, input int stall_k, input int stall_len);
        int s;
        logic [3:0] em;
        s = v + N - 1;
        for (int f = 1; f < N; f++) begin
            check_eq($sformatf("%s fill%0d wr_en", tag, f), 32'(acc_wr_en_o), 0);
            check_eq($sformatf("%s fill%0d rd_en", tag, f), 32'(acc_rd_en_o), 32'(add && f == N - 1));
            if (add && f == N - 1)
                check_eq($sformatf("%s rd_addr pre", tag), 32'(acc_rd_addr_o), base % 16);
            step();
        end
        for (int k = 0; k < s; k++) begin
            em = (v == 3) ? m3[k] : m2[k];
            check_eq($sformatf("%s k%0d wr_en", tag, k), 32'(acc_wr_en_o), 1);
            check_eq($sformatf("%s k%0d wr_addr", tag, k), 32'(acc_wr_addr_o), (base + k) % 16);
            check_eq($sformatf("%s k%0d mask", tag, k), 32'(acc_wr_mask_o), 32'(em));
            check_eq($sformatf("%s k%0d add", tag, k), 32'(acc_add_o), 32'(add));
            check_eq($sformatf("%s k%0d done", tag, k), 32'(done_o), 32'(last && k == s - 1));
            check_eq($sformatf("%s k%0d rd_en", tag, k), 32'(acc_rd_en_o), 32'(add && k + 1 < s));
            if (add && k + 1 < s)
                check_eq($sformatf("%s k%0d rd_addr", tag, k), 32'(acc_rd_addr_o), (base + k + 1) % 16);
            if (k == stall_k - 1 && stall_len > 0) begin
                stall_i = 1'b1;
                for (int b = 0; b < stall_len; b++) begin
                    step();
                    check_eq($sformatf("%s stall%0d wr_en", tag, b), 32'(acc_wr_en_o), 0);
                    check_eq($sformatf("%s stall%0d rd_en", tag, b), 32'(acc_rd_en_o), 0);
                    check_eq($sformatf("%s stall%0d done", tag, b), 32'(done_o), 0);
                    stall_i = (b + 1 < stall_len);
                end
            end
            if (k < s - 1) step();
        end
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        rst_i            = 1'b0;
        cmd_valid_i      = 1'b0;
        cmd_v_dim_i      = '0;
        cmd_u_dim_i      = '0;
        cmd_accumulate_i = 1'b0;
        act_start_i      = 1'b0;
        stall_i          = 1'b0;
        repeat (2) step();
        check_eq("rst ready", 32'(cmd_ready_o), 1);
        check_eq("rst busy", 32'(busy_o), 0);
        check_eq("rst wr_en", 32'(acc_wr_en_o), 0);
        check_eq("rst rd_en", 32'(acc_rd_en_o), 0);
        check_eq("rst done", 32'(done_o), 0);
        check_eq("rst err", 32'(err_o), 0);
        check_eq("rst mask", 32'(acc_wr_mask_o), 0);
        rst_i = 1'b1;
        step();

        // Single tile, then two more back to back: bases 0, 6, 12 (last one wraps).
        issue(3, 4, 0);
        check_eq("c1 busy after accept", 32'(busy_o), 1);
        check_eq("c1 ready after accept", 32'(cmd_ready_o), 0);
        act();
        check_wave("c1", 0, 3, 0, 1, -1, 0);
        step();
        check_eq("c1 ready after done", 32'(cmd_ready_o), 1);
        check_eq("c1 busy after done", 32'(busy_o), 0);
        check_eq("c1 done single pulse", 32'(done_o), 0);
        issue(3, 4, 0);
        act();
        check_wave("c4b", 6, 3, 0, 1, -1, 0);
        step();
        issue(3, 4, 0);
        act();
        check_wave("c4c", 12, 3, 0, 1, -1, 0);
        step();

        // Two-tile command from base 0; second tile accumulates.
        rst_i = 1'b0;
        step();
        rst_i = 1'b1;
        step();
        issue(2, 8, 0);
        act();
        check_wave("c2t0", 0, 2, 0, 0, -1, 0);
        step();
        check_eq("c2 between tiles busy", 32'(busy_o), 1);
        check_eq("c2 between tiles wr_en", 32'(acc_wr_en_o), 0);
        act();
        check_wave("c2t1", 0, 2, 1, 1, -1, 0);
        step();

        // Stall for two cycles ahead of step 2 at base 5.
        issue(3, 4, 0);
        act();
        check_wave("c3", 5, 3, 0, 1, 2, 2);
        step();
`ifdef ACCUM_STALL_CNT_EN
        check_eq("c3 stall count", stall_cycles_o, 2);
`endif

        // Zero-dimension rejection.
        issue(0, 4, 0);
        check_eq("c5 done", 32'(done_o), 1);
        check_eq("c5 err", 32'(err_o), 1);
        check_eq("c5 wr_en", 32'(acc_wr_en_o), 0);
        check_eq("c5 ready pulse cycle", 32'(cmd_ready_o), 0);
        step();
        check_eq("c5 ready again", 32'(cmd_ready_o), 1);
        check_eq("c5 done cleared", 32'(done_o), 0);
        check_eq("c5 err cleared", 32'(err_o), 0);
        issue(3, 0, 0);
        check_eq("c5u err", 32'(err_o), 1);
        step();

        // Reset in the middle of tile 1's wave at base 11.
        issue(2, 8, 0);
        act();
        check_wave("c6t0", 11, 2, 0, 0, -1, 0);
        step();
        act();
        repeat (3) step();
        check_eq("c6 k0 wr_addr", 32'(acc_wr_addr_o), 11);
        step();
        check_eq("c6 k1 wr_en", 32'(acc_wr_en_o), 1);
        #2;
        rst_i = 1'b0;
        #1;
        check_eq("c6 rst wr_en", 32'(acc_wr_en_o), 0);
        check_eq("c6 rst rd_en", 32'(acc_rd_en_o), 0);
        check_eq("c6 rst add", 32'(acc_add_o), 0);
        check_eq("c6 rst ready", 32'(cmd_ready_o), 1);
        check_eq("c6 rst busy", 32'(busy_o), 0);
        step();
        rst_i = 1'b1;
        step();
        check_eq("c6 no strobe after rst", 32'(acc_wr_en_o), 0);
        issue(3, 4, 0);
        act();
        check_wave("c6post", 0, 3, 0, 1, -1, 0);
        step();

        // Accumulate flag makes the single tile read-modify-write.
        issue(2, 3, 1);
        act();
        check_wave("acc", 6, 2, 1, 1, -1, 0);
        step();
        check_eq("acc ready after", 32'(cmd_ready_o), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
